// File: rtl/gray_chk_pkg.sv
// Shared types and default parameters for the gray stream checker.
package gray_chk_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    // Class of one sample-to-sample transition of the synchronised gray vector
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        STEP = 2'd1,
        BAD  = 2'd2
    } tclass_e;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_COUNT  = 4;
    localparam int DEF_ERR_CNT_W   = 8;

endpackage

// File: rtl/gray_stream_checker_if.sv
// Sample/status bundle between a gray source (master) and the checker (slave).
// err_sticky exists only when GRAY_CHK_STICKY_EN is defined.
interface gray_stream_checker_if #(
    parameter int WIDTH     = gray_chk_pkg::DEF_WIDTH,
    parameter int ERR_CNT_W = gray_chk_pkg::DEF_ERR_CNT_W
);
    logic [WIDTH-1:0]     gray_in;
    logic                 clear_err;
    logic [WIDTH-1:0]     bin_out;
    logic                 locked;
    logic                 wrap_pulse;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
`ifdef GRAY_CHK_STICKY_EN
    logic                 err_sticky;

    modport master (
        output gray_in, clear_err,
        input  bin_out, locked, wrap_pulse, err_pulse, err_count, err_sticky
    );
    modport slave (
        input  gray_in, clear_err,
        output bin_out, locked, wrap_pulse, err_pulse, err_count, err_sticky
    );
`else
    modport master (
        output gray_in, clear_err,
        input  bin_out, locked, wrap_pulse, err_pulse, err_count
    );
    modport slave (
        input  gray_in, clear_err,
        output bin_out, locked, wrap_pulse, err_pulse, err_count
    );
`endif
endinterface

// File: rtl/gray_stream_checker_g2b.sv
// Combinational gray-to-binary decode: bin[i] is the XOR of gray[WIDTH-1:i].
module gray_to_bin #(
    parameter int WIDTH = gray_chk_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end
endmodule

// File: rtl/gray_stream_checker.sv
// Synchronises an upstream gray count, decodes it and tracks lock/wrap/error status.
// Optional GRAY_CHK_STICKY_EN adds a sticky error flag on the interface.
module gray_stream_checker
    import gray_chk_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int ERR_CNT_W   = DEF_ERR_CNT_W
) (
    input logic                 clock,
    input logic                 reset,
    gray_stream_checker_if.slave bus
);
    localparam int LCW = $clog2(LOCK_COUNT + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]     g_cur, g_prev;
    logic [WIDTH-1:0]     b_cur, b_prev, b_inc, diff;
    logic                 one_hot;
    tclass_e              cls;
    state_e               state;
    logic [LCW-1:0]       lock_cnt;
    logic                 err_evt;
    logic [WIDTH-1:0]     bin_q;
    logic                 locked_q, wrap_q, err_q;
    logic [ERR_CNT_W-1:0] err_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= bus.gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign g_cur = sync_q[SYNC_STAGES-1];

    gray_to_bin #(.WIDTH(WIDTH)) u_dec_cur  (.gray(g_cur),  .bin(b_cur));
    gray_to_bin #(.WIDTH(WIDTH)) u_dec_prev (.gray(g_prev), .bin(b_prev));

    // A legal move is a single-bit gray change that advances the binary by one;
    // a single-bit backward move is still an error.
    always_comb begin
        diff    = g_cur ^ g_prev;
        b_inc   = b_prev + WIDTH'(1);
        one_hot = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
        cls     = BAD;
        if (diff == '0)
            cls = HOLD;
        else if (one_hot && (b_cur == b_inc))
            cls = STEP;
    end

    assign err_evt = (state == LOCKED) && (cls == BAD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
            g_prev   <= '0;
            bin_q    <= '0;
            locked_q <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            g_prev <= g_cur;
            bin_q  <= b_cur;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                UNLOCKED: begin
                    if (cls == STEP) begin
                        if (lock_cnt == LCW'(LOCK_COUNT - 1)) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + LCW'(1);
                        end
                    end else if (cls == BAD) begin
                        lock_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (cls == BAD) begin
                        state    <= UNLOCKED;
                        locked_q <= 1'b0;
                        lock_cnt <= '0;
                        err_q    <= 1'b1;
                    end else if (cls == STEP && b_prev == '1) begin
                        wrap_q <= 1'b1;
                    end
                end
                default: state <= UNLOCKED;
            endcase
        end
    end

    // A clear coinciding with a counted error keeps that error visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_cnt <= '0;
        else if (bus.clear_err)
            err_cnt <= err_evt ? ERR_CNT_W'(1) : '0;
        else if (err_evt && err_cnt != '1)
            err_cnt <= err_cnt + ERR_CNT_W'(1);
    end

`ifdef GRAY_CHK_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sticky_q <= 1'b0;
        else if (err_evt)
            sticky_q <= 1'b1;
        else if (bus.clear_err)
            sticky_q <= 1'b0;
    end

    assign bus.err_sticky = sticky_q;
`endif

    assign bus.bin_out    = bin_q;
    assign bus.locked     = locked_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.err_pulse  = err_q;
    assign bus.err_count  = err_cnt;

    a_pulse_excl: assert property (@(posedge clock) disable iff (reset) !(wrap_q && err_q));
    a_err_once:   assert property (@(posedge clock) disable iff (reset) err_q |=> !err_q);

endmodule

// File: doc/gray_stream_checker.md
Name: gray_stream_checker

Overview:
Downstream consumer of the 4-bit gray counter. Synchronises the incoming gray vector, decodes it to binary and classifies every sample-to-sample transition as hold, valid +1 step or illegal. Provides lock status, wrap detection and a saturating error count for debug and self-check of the counter stage.

Parameters:
WIDTH, 4, gray/binary vector width
SYNC_STAGES, 2, flops in input synchroniser chain (min 1)
LOCK_COUNT, 4, consecutive valid +1 steps needed to declare lock (1..2**WIDTH)
ERR_CNT_W, 8, error counter width

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
gray_in  input  WIDTH  gray code from upstream counter
clear_err  input  1  synchronous clear of err_count (and sticky flag)
bin_out  output  WIDTH  registered binary decode of synchronised gray
locked  output  1  high while transition stream is trusted
wrap_pulse  output  1  one-cycle pulse on valid step from all-ones to 0 (binary) while locked
err_pulse  output  1  one-cycle pulse on illegal transition while locked
err_count  output  ERR_CNT_W  saturating count of err_pulse events

Behaviour:
- Reset (async, takes effect immediately, no clock edge needed): sync chain, g_prev, bin_out, lock_cnt, err_count = 0; locked, wrap_pulse, err_pulse = 0; FSM = UNLOCKED.
- gray_in passes through SYNC_STAGES flops; last stage is g_cur. g_prev registers g_cur every cycle.
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i].
- Classification (combinational on g_cur, g_prev):
  HOLD: g_cur == g_prev (covers upstream enable low).
  STEP: exactly one bit differs AND bin(g_cur) == bin(g_prev)+1 mod 2**WIDTH.
  BAD: anything else (multi-bit change, or single-bit backward step).
- All outputs registered; latency gray_in to bin_out = SYNC_STAGES+1 cycles; pulses align with the bin_out of the sample that caused them.
- FSM UNLOCKED: STEP -> lock_cnt+1; BAD -> lock_cnt=0; HOLD -> unchanged. When the increment reaches LOCK_COUNT: go LOCKED, locked=1 next cycle, lock_cnt=0.
- FSM LOCKED: HOLD/STEP stay. STEP with bin(g_prev)=all-ones -> wrap_pulse=1. BAD -> err_pulse=1, err_count+1 (saturating at all-ones), go UNLOCKED, locked=0, lock_cnt=0.
- Errors in UNLOCKED never raise err_pulse or change err_count.
- clear_err alone: err_count=0 next cycle. clear_err with simultaneous counted error: err_count=1.
- Pulses never held longer than one cycle; wrap_pulse and err_pulse mutually exclusive.

Optional Feature:
GRAY_CHK_STICKY_EN defined: extra output port err_sticky (1 bit), set the cycle err_pulse asserts, held until clear_err or reset (clear_err with simultaneous error -> stays 1). Not defined: port and logic absent; all other behaviour identical.

Decomposition:
- Package gray_chk_pkg: FSM state enum (UNLOCKED, LOCKED), transition class enum (HOLD, STEP, BAD), default-parameter constants.
- One sub-module: gray_to_bin (parameterised WIDTH, purely combinational), instantiated for g_cur and g_prev.
- Synchroniser, classifier, FSM, counters live in gray_stream_checker.

Test Plan:
- Reset, drive gray 0,1,3,2,6 one per cycle -> bin_out 0,1,2,3,4 each 3 cycles later; locked rises with the bin_out=4 sample, no pulses.
- Locked, drive gray 0x9 then 0x8 then 0x0 (bin 14,15,0) -> wrap_pulse exactly one cycle aligned with bin_out=0; err_count stays 0.
- Locked, jump gray 0x2 to 0x5 -> err_pulse one cycle, err_count=1, locked=0; then 4 valid steps -> locked=1 again.
- Locked, backward gray 0x3 to 0x1 (bin 2 to 1) -> classified BAD, err_pulse, err_count+1; holding gray constant 10 cycles -> no change.
- ERR_CNT_W=2: force 5 locked errors -> err_count saturates at 3; clear_err with concurrent error -> err_count=1; (STICKY_EN) err_sticky stays 1.
- Mid-lock, assert reset between clock edges -> bin_out, locked, err_count, pulses 0 immediately; release -> requires LOCK_COUNT steps to relock.
